// File: rtl/mpu_run_ctrl.sv
// mpu_run_ctrl: run/halt/debug controller for the soft MPU.
// Drives a clock enable and a synchronous core reset into the datapath and
// controller, sequences a core restart, supports single-step and a PC
// breakpoint, and keeps saturating cycle and instruction counters.
module mpu_run_ctrl #(
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_restart,
  input  logic             i_step,
  input  logic             i_halt_in,
  input  logic             i_instr_done,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             i_bp_en,
  input  logic [PC_W-1:0]  i_bp_addr,
  output logic             o_cpu_en,
  output logic             o_cpu_rst,
  output logic [2:0]       o_state,
  output logic             o_bp_hit,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instr_cnt
);

  // Width of the reset-hold counter; it only ever holds RST_CYC-1 down to 0.
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_RESET = 3'b001,
    S_RUN   = 3'b010,
    S_STEP  = 3'b011,
    S_PAUSE = 3'b100,
    S_HALT  = 3'b101
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RC_W-1:0]   r_rstCnt;
  logic              r_bpArm;
  logic              r_bpHit;
  logic [CNT_W-1:0]  r_cycleCnt;
  logic [CNT_W-1:0]  r_instrCnt;
  logic              w_bpMatch;
  logic              w_enterReset;
  logic              w_enterRun;
  logic              w_coreActive;

  assign w_bpMatch    = i_instr_done & i_bp_en & r_bpArm & (i_pc == i_bp_addr);
  assign w_enterReset = (w_next == S_RESET) && ((r_state != S_RESET) || i_restart);
  assign w_enterRun   = (w_next == S_RUN) && (r_state != S_RUN);
  assign w_coreActive = o_cpu_en & ~o_cpu_rst;

  // Registered state; rst forces IDLE immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; restart wins, then halt, breakpoint, start, step.
  always_comb begin
    w_next = r_state;
    if (i_restart) begin
      w_next = S_RESET;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = S_RESET;
        S_RESET: if (r_rstCnt == '0) w_next = S_RUN;
        S_RUN: begin
          if (i_halt_in)      w_next = S_HALT;
          else if (w_bpMatch) w_next = S_PAUSE;
        end
        S_PAUSE: begin
          if (i_start)     w_next = S_RUN;
          else if (i_step) w_next = S_STEP;
        end
        S_STEP: begin
          if (i_halt_in)         w_next = S_HALT;
          else if (i_instr_done) w_next = S_PAUSE;
        end
        S_HALT:  w_next = S_HALT;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Core enable/reset are a pure decode of the registered state.
  always_comb begin
    o_cpu_en  = 1'b0;
    o_cpu_rst = 1'b0;
    case (r_state)
      S_IDLE:  begin o_cpu_en = 1'b0; o_cpu_rst = 1'b1; end
      S_RESET: begin o_cpu_en = 1'b1; o_cpu_rst = 1'b1; end
      S_RUN:   begin o_cpu_en = 1'b1; o_cpu_rst = 1'b0; end
      S_STEP:  begin o_cpu_en = 1'b1; o_cpu_rst = 1'b0; end
      default: begin o_cpu_en = 1'b0; o_cpu_rst = 1'b0; end
    endcase
  end

  // Reset-hold counter: loaded on every RESET entry, counts down while in RESET.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                     r_rstCnt <= '0;
    else if (w_enterReset)                         r_rstCnt <= RC_LOAD;
    else if ((r_state == S_RESET) && (r_rstCnt != '0)) r_rstCnt <= r_rstCnt - 1'b1;
  end

  // Breakpoint arm: dropped on RUN entry so a resume skips the current PC.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                  r_bpArm <= 1'b0;
    else if (w_enterRun)                        r_bpArm <= 1'b0;
    else if ((r_state == S_RUN) && i_instr_done) r_bpArm <= 1'b1;
  end

  // Sticky breakpoint flag: set only on a breakpoint stop, cleared leaving PAUSE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                        r_bpHit <= 1'b0;
    else if ((r_state == S_RUN) && (w_next == S_PAUSE))   r_bpHit <= 1'b1;
    else if ((r_state == S_PAUSE) && (w_next != S_PAUSE)) r_bpHit <= 1'b0;
  end

  // Saturating cycle and instruction counters, cleared on RESET entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cycleCnt <= '0;
      r_instrCnt <= '0;
    end else if (w_enterReset) begin
      r_cycleCnt <= '0;
      r_instrCnt <= '0;
    end else begin
      if (w_coreActive && (r_cycleCnt != CNT_MAX))
        r_cycleCnt <= r_cycleCnt + 1'b1;
      if (i_instr_done && o_cpu_en && (r_instrCnt != CNT_MAX))
        r_instrCnt <= r_instrCnt + 1'b1;
    end
  end

  assign o_state     = r_state;
  assign o_bp_hit    = r_bpHit;
  assign o_cycle_cnt = r_cycleCnt;
  assign o_instr_cnt = r_instrCnt;

endmodule

// File: tb/tb_mpu_run_ctrl.sv
// tb_mpu_run_ctrl: directed bench for the run/halt/debug controller.
// A 16-bit-counter instance and a 4-bit-counter instance share all inputs.
module tb_mpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        step = 1'b0;
  logic        haltIn = 1'b0;
  logic        instrDone = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        bpEn = 1'b0;
  logic [7:0]  bpAddr = 8'h00;

  logic        cpuEn, cpuRst, bpHit;
  logic [2:0]  state;
  logic [15:0] cycleCnt, instrCnt;
  logic        cpuEn4, cpuRst4, bpHit4;
  logic [2:0]  state4;
  logic [3:0]  cycleCnt4, instrCnt4;

  int total = 0;
  int bad = 0;

  mpu_run_ctrl #(.PC_W(8), .CNT_W(16), .RST_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_restart(restart), .i_step(step),
    .i_halt_in(haltIn), .i_instr_done(instrDone), .i_pc(pc), .i_bp_en(bpEn),
    .i_bp_addr(bpAddr), .o_cpu_en(cpuEn), .o_cpu_rst(cpuRst), .o_state(state),
    .o_bp_hit(bpHit), .o_cycle_cnt(cycleCnt), .o_instr_cnt(instrCnt)
  );

  mpu_run_ctrl #(.PC_W(8), .CNT_W(4), .RST_CYC(2)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_restart(restart), .i_step(step),
    .i_halt_in(haltIn), .i_instr_done(instrDone), .i_pc(pc), .i_bp_en(bpEn),
    .i_bp_addr(bpAddr), .o_cpu_en(cpuEn4), .o_cpu_rst(cpuRst4), .o_state(state4),
    .o_bp_hit(bpHit4), .o_cycle_cnt(cycleCnt4), .o_instr_cnt(instrCnt4)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (state !== 3'b000) begin bad++; $display("[TB] FAIL rst_state got=%b want=000", state); end
    total++; if (cpuEn !== 1'b0) begin bad++; $display("[TB] FAIL rst_cpu_en got=%b want=0", cpuEn); end
    total++; if (cpuRst !== 1'b1) begin bad++; $display("[TB] FAIL rst_cpu_rst got=%b want=1", cpuRst); end
    total++; if (bpHit !== 1'b0) begin bad++; $display("[TB] FAIL rst_bp_hit got=%b want=0", bpHit); end
    total++; if (cycleCnt !== 16'd0 || instrCnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_counters got=%0d/%0d want=0/0", cycleCnt, instrCnt); end
    total++; if (state4 !== 3'b000 || cycleCnt4 !== 4'd0) begin bad++; $display("[TB] FAIL rst_dut4 got=%b/%0d want=000/0", state4, cycleCnt4); end
    rst = 1'b0;
    tick(); tick();
    total++; if (state !== 3'b000) begin bad++; $display("[TB] FAIL idle_hold got=%b want=000", state); end
  endtask

  task automatic test_startup();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 3'b001 || cpuEn !== 1'b1 || cpuRst !== 1'b1) begin bad++; $display("[TB] FAIL reset_c1 got=%b en=%b rst=%b want=001 en=1 rst=1", state, cpuEn, cpuRst); end
    tick();
    total++; if (state !== 3'b001 || cpuEn !== 1'b1 || cpuRst !== 1'b1) begin bad++; $display("[TB] FAIL reset_c2 got=%b en=%b rst=%b want=001 en=1 rst=1", state, cpuEn, cpuRst); end
    tick();
    total++; if (state !== 3'b010 || cpuEn !== 1'b1 || cpuRst !== 1'b0) begin bad++; $display("[TB] FAIL run_entry got=%b en=%b rst=%b want=010 en=1 rst=0", state, cpuEn, cpuRst); end
    total++; if (cycleCnt !== 16'd0) begin bad++; $display("[TB] FAIL run_entry_cycles got=%0d want=0", cycleCnt); end
  endtask

  task automatic test_halt();
    repeat (37) tick();
    total++; if (cycleCnt !== 16'd37) begin bad++; $display("[TB] FAIL run_cycles got=%0d want=37", cycleCnt); end
    haltIn = 1'b1;
    tick();
    haltIn = 1'b0;
    total++; if (state !== 3'b101 || cpuEn !== 1'b0) begin bad++; $display("[TB] FAIL halt_state got=%b en=%b want=101 en=0", state, cpuEn); end
    total++; if (cycleCnt !== 16'd38) begin bad++; $display("[TB] FAIL halt_cycles got=%0d want=38", cycleCnt); end
    start = 1'b1;
    instrDone = 1'b1;
    tick(); tick();
    start = 1'b0;
    instrDone = 1'b0;
    total++; if (state !== 3'b101 || cycleCnt !== 16'd38) begin bad++; $display("[TB] FAIL halt_sticky got=%b/%0d want=101/38", state, cycleCnt); end
    total++; if (instrCnt !== 16'd0) begin bad++; $display("[TB] FAIL halt_instr_ignored got=%0d want=0", instrCnt); end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    total++; if (state !== 3'b001 || cycleCnt !== 16'd0 || instrCnt !== 16'd0) begin bad++; $display("[TB] FAIL restart got=%b/%0d/%0d want=001/0/0", state, cycleCnt, instrCnt); end
    tick(); tick();
    total++; if (state !== 3'b010) begin bad++; $display("[TB] FAIL restart_run got=%b want=010", state); end
  endtask

  task automatic test_breakpoint();
    bpEn = 1'b1;
    bpAddr = 8'h0C;
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i * 4);
      instrDone = 1'b1;
      tick();
      instrDone = 1'b0;
      if (i < 3) tick();
    end
    total++; if (state !== 3'b100 || bpHit !== 1'b1 || cpuEn !== 1'b0) begin bad++; $display("[TB] FAIL bp_pause got=%b hit=%b en=%b want=100 hit=1 en=0", state, bpHit, cpuEn); end
    total++; if (instrCnt !== 16'd4 || cycleCnt !== 16'd7) begin bad++; $display("[TB] FAIL bp_counts got=%0d/%0d want=4/7", instrCnt, cycleCnt); end
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    total++; if (state !== 3'b100 || instrCnt !== 16'd4 || cycleCnt !== 16'd7) begin bad++; $display("[TB] FAIL pause_frozen got=%b/%0d/%0d want=100/4/7", state, instrCnt, cycleCnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (state !== 3'b010 || bpHit !== 1'b0) begin bad++; $display("[TB] FAIL bp_resume got=%b hit=%b want=010 hit=0", state, bpHit); end
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    total++; if (state !== 3'b010 || bpHit !== 1'b0 || instrCnt !== 16'd5) begin bad++; $display("[TB] FAIL bp_no_rehit got=%b hit=%b instr=%0d want=010 hit=0 instr=5", state, bpHit, instrCnt); end
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    total++; if (state !== 3'b100 || bpHit !== 1'b1 || cycleCnt !== 16'd9) begin bad++; $display("[TB] FAIL bp_rearm got=%b hit=%b cyc=%0d want=100 hit=1 cyc=9", state, bpHit, cycleCnt); end
  endtask

  task automatic test_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    total++; if (state !== 3'b011 || cpuEn !== 1'b1 || cpuRst !== 1'b0 || bpHit !== 1'b0) begin bad++; $display("[TB] FAIL step_entry got=%b en=%b rst=%b hit=%b want=011 en=1 rst=0 hit=0", state, cpuEn, cpuRst, bpHit); end
    tick();
    total++; if (state !== 3'b011 || cycleCnt !== 16'd10) begin bad++; $display("[TB] FAIL step_wait got=%b/%0d want=011/10", state, cycleCnt); end
    pc = 8'h0C;
    instrDone = 1'b1;
    tick();
    instrDone = 1'b0;
    total++; if (state !== 3'b100 || bpHit !== 1'b0) begin bad++; $display("[TB] FAIL step_done got=%b hit=%b want=100 hit=0", state, bpHit); end
    total++; if (instrCnt !== 16'd7 || cycleCnt !== 16'd11) begin bad++; $display("[TB] FAIL step_counts got=%0d/%0d want=7/11", instrCnt, cycleCnt); end
    start = 1'b1;
    step = 1'b1;
    tick();
    start = 1'b0;
    step = 1'b0;
    total++; if (state !== 3'b010) begin bad++; $display("[TB] FAIL start_over_step got=%b want=010", state); end
  endtask

  task automatic test_halt_vs_bp();
    pc = 8'h10;
    instrDone = 1'b1;
    tick();
    pc = 8'h0C;
    haltIn = 1'b1;
    tick();
    instrDone = 1'b0;
    haltIn = 1'b0;
    total++; if (state !== 3'b101 || bpHit !== 1'b0) begin bad++; $display("[TB] FAIL halt_over_bp got=%b hit=%b want=101 hit=0", state, bpHit); end
    total++; if (instrCnt !== 16'd9 || cycleCnt !== 16'd13) begin bad++; $display("[TB] FAIL halt_over_bp_counts got=%0d/%0d want=9/13", instrCnt, cycleCnt); end
  endtask

  task automatic test_saturate();
    bpEn = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    tick(); tick();
    total++; if (state4 !== 3'b010 || cycleCnt4 !== 4'd0) begin bad++; $display("[TB] FAIL sat_start got=%b/%0d want=010/0", state4, cycleCnt4); end
    instrDone = 1'b1;
    repeat (15) tick();
    total++; if (cycleCnt4 !== 4'd15 || instrCnt4 !== 4'd15) begin bad++; $display("[TB] FAIL sat_reach got=%0d/%0d want=15/15", cycleCnt4, instrCnt4); end
    repeat (5) tick();
    instrDone = 1'b0;
    total++; if (cycleCnt4 !== 4'd15 || instrCnt4 !== 4'd15) begin bad++; $display("[TB] FAIL sat_hold got=%0d/%0d want=15/15", cycleCnt4, instrCnt4); end
    total++; if (cycleCnt !== 16'd20 || instrCnt !== 16'd20) begin bad++; $display("[TB] FAIL wide_count got=%0d/%0d want=20/20", cycleCnt, instrCnt); end
    rst = 1'b1;
    #1;
    total++; if (state !== 3'b000 || cpuEn !== 1'b0 || cpuRst !== 1'b1) begin bad++; $display("[TB] FAIL async_rst got=%b en=%b rst=%b want=000 en=0 rst=1", state, cpuEn, cpuRst); end
    total++; if (cycleCnt !== 16'd0 || cycleCnt4 !== 4'd0 || instrCnt !== 16'd0) begin bad++; $display("[TB] FAIL async_rst_cnt got=%0d/%0d/%0d want=0/0/0", cycleCnt, cycleCnt4, instrCnt); end
    tick();
    rst = 1'b0;
    tick();
    total++; if (state !== 3'b000) begin bad++; $display("[TB] FAIL post_rst_idle got=%b want=000", state); end
  endtask

  // Scenario sequence and summary.
  initial begin
    $display("[TB] starting mpu_run_ctrl directed tests");
    test_reset();
    test_startup();
    test_halt();
    test_breakpoint();
    test_step();
    test_halt_vs_bp();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
